// File: rtl/mmss_if.sv
// Control, preset, detector-flag and digit bundle between the keypad/detector side and the mm:ss timer.
// The master modport belongs to whoever drives the pulses and the flags; the slave modport belongs to the timer.
interface mmss_if;
  logic        tick;
  logic        start_pause;
  logic        clear;
  logic        load;
  logic [15:0] load_val;
  logic        dir;
  logic        zero0, zero1, zero2, zero3;
  logic        top0, top1, top2, top3;
  logic [3:0]  s0, s1, m0, m1;
  logic        running;
  logic        done;

  modport slave (
    input  tick, start_pause, clear, load, load_val, dir,
    input  zero0, zero1, zero2, zero3, top0, top1, top2, top3,
    output s0, s1, m0, m1, running, done
  );

  modport master (
    output tick, start_pause, clear, load, load_val, dir,
    output zero0, zero1, zero2, zero3, top0, top1, top2, top3,
    input  s0, s1, m0, m1, running, done
  );
endinterface

// File: rtl/mmss_timer_counter.sv
// mm:ss BCD up/down timer core. Carry/borrow and terminal count come from the external
// zero/top detector that decodes the digits driven here.
module mmss_timer_counter (
  input  logic   clk,
  input  logic   rst_n,
  mmss_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  state_t     state_q, state_d;
  logic [3:0] s0_q, s1_q, m0_q, m1_q;
  logic [3:0] s0_d, s1_d, m0_d, m1_d;
  logic       running_q, done_q;
  logic       term;

  function automatic logic [3:0] clamp(input logic [3:0] v, input logic [3:0] mx);
    return (v > mx) ? mx : v;
  endfunction

  // Terminal count is judged on the current digits, so it lags the final tick by one cycle.
  assign term = bus.dir ? bus.zero3 : bus.top3;

  always_comb begin
    state_d = state_q;
    s0_d    = s0_q;
    s1_d    = s1_q;
    m0_d    = m0_q;
    m1_d    = m1_q;
    if (bus.clear) begin
      state_d = IDLE;
      s0_d    = 4'd0;
      s1_d    = 4'd0;
      m0_d    = 4'd0;
      m1_d    = 4'd0;
    end else if (bus.load && state_q != RUN) begin
      s0_d = clamp(bus.load_val[3:0],   4'd9);
      s1_d = clamp(bus.load_val[7:4],   4'd5);
      m0_d = clamp(bus.load_val[11:8],  4'd9);
      m1_d = clamp(bus.load_val[15:12], 4'd5);
      if (state_q == DONE) state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:  if (bus.start_pause) state_d = RUN;
        PAUSE: if (bus.start_pause) state_d = RUN;
        DONE:  ;
        RUN: begin
          if (term) begin
            state_d = DONE;
          end else if (bus.start_pause) begin
            state_d = PAUSE;
          end else if (bus.tick) begin
            if (!bus.dir) begin
              s0_d = bus.top0 ? 4'd0 : 4'(s0_q + 4'd1);
              if (bus.top0) s1_d = bus.top1 ? 4'd0 : 4'(s1_q + 4'd1);
              if (bus.top1) m0_d = bus.top2 ? 4'd0 : 4'(m0_q + 4'd1);
              if (bus.top2) m1_d = 4'(m1_q + 4'd1);
            end else begin
              s0_d = bus.zero0 ? 4'd9 : 4'(s0_q - 4'd1);
              if (bus.zero0) s1_d = bus.zero1 ? 4'd5 : 4'(s1_q - 4'd1);
              if (bus.zero1) m0_d = bus.zero2 ? 4'd9 : 4'(m0_q - 4'd1);
              if (bus.zero2) m1_d = 4'(m1_q - 4'd1);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      s0_q      <= 4'd0;
      s1_q      <= 4'd0;
      m0_q      <= 4'd0;
      m1_q      <= 4'd0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      s0_q      <= s0_d;
      s1_q      <= s1_d;
      m0_q      <= m0_d;
      m1_q      <= m1_d;
      running_q <= (state_d == RUN);
      done_q    <= (state_d == DONE);
    end
  end

  assign bus.s0      = s0_q;
  assign bus.s1      = s1_q;
  assign bus.m0      = m0_q;
  assign bus.m1      = m1_q;
  assign bus.running = running_q;
  assign bus.done    = done_q;

endmodule

// File: tb/tb_mmss_timer_counter.sv
// Bench for mmss_timer_counter: models the timer as a seconds count (0..3599) plus a mode,
// supplies the zero/top detector, and checks digits/running/done every cycle.
module tb_mmss_timer_counter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  mmss_if bif();

  mmss_timer_counter dut (.clk(clk), .rst_n(rst_n), .bus(bif.slave));

  always #5 clk = ~clk;

  // Detector: cumulative zero / at-max flags on the DUT digits.
  assign bif.zero0 = (bif.s0 == 4'd0);
  assign bif.zero1 = bif.zero0 && (bif.s1 == 4'd0);
  assign bif.zero2 = bif.zero1 && (bif.m0 == 4'd0);
  assign bif.zero3 = bif.zero2 && (bif.m1 == 4'd0);
  assign bif.top0  = (bif.s0 == 4'd9);
  assign bif.top1  = bif.top0 && (bif.s1 == 4'd5);
  assign bif.top2  = bif.top1 && (bif.m0 == 4'd9);
  assign bif.top3  = bif.top2 && (bif.m1 == 4'd5);

  // Reference model: mode 0 idle, 1 run, 2 pause, 3 done; t = elapsed seconds.
  int mode;
  int t;

  function automatic int lim(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  function automatic int bcd_to_sec(input logic [15:0] v);
    int d0, d1, d2, d3;
    d0 = lim(int'(v[3:0]), 9);
    d1 = lim(int'(v[7:4]), 5);
    d2 = lim(int'(v[11:8]), 9);
    d3 = lim(int'(v[15:12]), 5);
    return (d3 * 10 + d2) * 60 + d1 * 10 + d0;
  endfunction

  function automatic logic [15:0] sec_to_bcd(input int s);
    int mm, ss;
    mm = s / 60;
    ss = s % 60;
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode = 0;
      t    = 0;
    end else if (bif.clear) begin
      mode = 0;
      t    = 0;
    end else if (bif.load && mode != 1) begin
      t = bcd_to_sec(bif.load_val);
      if (mode == 3) mode = 0;
    end else if (mode == 1) begin
      if ((!bif.dir && t == 3599) || (bif.dir && t == 0)) mode = 3;
      else if (bif.start_pause) mode = 2;
      else if (bif.tick) t = bif.dir ? t - 1 : t + 1;
    end else if (mode != 3 && bif.start_pause) begin
      mode = 1;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  logic [15:0] dig;
  assign dig = {bif.m1, bif.m0, bif.s1, bif.s0};

  always @(negedge clk) begin
    check("model_digits", int'(dig), int'(sec_to_bcd(t)));
    check("model_running", int'(bif.running), int'(mode == 1));
    check("model_done", int'(bif.done), int'(mode == 3));
  end

  task automatic drive(input logic tk, input logic sp, input logic cl,
                       input logic ld, input logic [15:0] lv);
    bif.tick = tk; bif.start_pause = sp; bif.clear = cl; bif.load = ld; bif.load_val = lv;
    @(posedge clk); #2;
    bif.tick = 0; bif.start_pause = 0; bif.clear = 0; bif.load = 0;
  endtask

  task automatic lit(input string name, input logic [15:0] d, input logic r, input logic dn);
    check({name, "_dig"}, int'(dig), int'(d));
    check({name, "_run"}, int'(bif.running), int'(r));
    check({name, "_done"}, int'(bif.done), int'(dn));
  endtask

  logic [15:0] picks [6] = '{16'h5958, 16'h0001, 16'h0000, 16'h5959, 16'h0959, 16'h1000};

  initial begin
    bif.tick = 0; bif.start_pause = 0; bif.clear = 0; bif.load = 0;
    bif.load_val = '0; bif.dir = 0;
    #23;
    lit("reset", 16'h0000, 0, 0);
    @(posedge clk); #2; rst_n = 1;

    // Up count across the minute boundary.
    drive(0, 0, 0, 1, 16'h0958);
    drive(0, 1, 0, 0, 16'h0);
    lit("up_start", 16'h0958, 1, 0);
    drive(1, 0, 0, 0, 16'h0);
    lit("up_t1", 16'h0959, 1, 0);
    drive(1, 0, 0, 0, 16'h0);
    lit("up_t2", 16'h1000, 1, 0);

    // Down count with borrow, then down to zero and done one cycle later.
    drive(0, 0, 1, 0, 16'h0);
    bif.dir = 1;
    drive(0, 0, 0, 1, 16'h1000);
    drive(0, 1, 0, 0, 16'h0);
    drive(1, 0, 0, 0, 16'h0);
    lit("dn_borrow", 16'h0959, 1, 0);
    drive(0, 0, 1, 0, 16'h0);
    drive(0, 0, 0, 1, 16'h0001);
    drive(0, 1, 0, 0, 16'h0);
    drive(1, 0, 0, 0, 16'h0);
    lit("dn_zero", 16'h0000, 1, 0);
    drive(0, 0, 0, 0, 16'h0);
    lit("dn_done", 16'h0000, 0, 1);

    // Up to terminal, DONE holds against tick/start_pause, clear returns to idle.
    drive(0, 0, 1, 0, 16'h0);
    bif.dir = 0;
    drive(0, 0, 0, 1, 16'h5958);
    drive(0, 1, 0, 0, 16'h0);
    drive(1, 0, 0, 0, 16'h0);
    lit("top_reach", 16'h5959, 1, 0);
    drive(1, 0, 0, 0, 16'h0);
    lit("top_done", 16'h5959, 0, 1);
    drive(1, 1, 0, 0, 16'h0);
    lit("top_hold", 16'h5959, 0, 1);
    drive(0, 0, 1, 0, 16'h0);
    lit("top_clear", 16'h0000, 0, 0);

    // Pause with coincident tick; load beats start_pause outside RUN.
    drive(0, 0, 0, 1, 16'h0003);
    drive(0, 1, 0, 0, 16'h0);
    drive(1, 0, 0, 0, 16'h0);
    drive(1, 0, 0, 0, 16'h0);
    lit("pr_run", 16'h0005, 1, 0);
    drive(1, 1, 0, 0, 16'h0);
    lit("pr_pause", 16'h0005, 0, 0);
    drive(0, 1, 0, 1, 16'h0100);
    lit("pr_loadsp", 16'h0100, 0, 0);
    drive(0, 1, 0, 0, 16'h0);
    lit("pr_resume", 16'h0100, 1, 0);

    // Clamp, and load ignored while running.
    drive(0, 0, 1, 0, 16'h0);
    drive(0, 0, 0, 1, 16'hFA7C);
    lit("clamp", 16'h5959, 0, 0);
    drive(0, 0, 1, 0, 16'h0);
    drive(0, 0, 0, 1, 16'h0010);
    drive(0, 1, 0, 0, 16'h0);
    drive(0, 0, 0, 1, 16'h1234);
    lit("run_load", 16'h0010, 1, 0);

    // Start at 00:00 counting down: RUN then DONE.
    drive(0, 0, 1, 0, 16'h0);
    bif.dir = 1;
    drive(0, 1, 0, 0, 16'h0);
    lit("z_start", 16'h0000, 1, 0);
    drive(0, 0, 0, 0, 16'h0);
    lit("z_done", 16'h0000, 0, 1);

    // Asynchronous reset mid-run at 12:34.
    drive(0, 0, 1, 0, 16'h0);
    bif.dir = 0;
    drive(0, 0, 0, 1, 16'h1234);
    drive(0, 1, 0, 0, 16'h0);
    lit("ar_pre", 16'h1234, 1, 0);
    #1 rst_n = 0;
    #1 lit("ar_async", 16'h0000, 0, 0);
    @(posedge clk); #2; rst_n = 1;

    // Randomized phase.
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] lv;
      lv = ($urandom_range(1) == 0) ? 16'($urandom) : picks[$urandom_range(5)];
      if ($urandom_range(39) == 0) bif.dir = ~bif.dir;
      drive(1'($urandom_range(1)), $urandom_range(14) == 0, $urandom_range(299) == 0,
            $urandom_range(24) == 0, lv);
    end

    @(posedge clk); #2;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
